alu_seq: RTL and testbench

Parametrised, registered successor to the team's 4-bit combinational ALU. It keeps the same 16-entry opcode map, and adds:
- a WIDTH parameter;
- a valid/ready handshake on input and output;
- a full-width multiply high half;
- status flags;
- a multi-cycle restoring divider for quotient and remainder.

It sits between an operand-issue stage and a result-writeback stage, and processes one operation at a time.

---
 rtl/alu_seq.sv | 225 ++++++++++++++++++++++
 tb/tb_alu_seq.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered 16-opcode ALU with valid/ready handshake and multi-cycle restoring divider
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operands/opcode valid        in_ready  block can accept (IDLE and not in reset)
//   a, b       WIDTH-bit operands           op        4-bit opcode
//   out_valid  result registers hold a completed result
//   out_ready  consumer takes the result
//   y          result                       y_hi      upper product half (mul only)
//   carry      add carry / sub borrow       ovf       two's-complement overflow (add/sub)
//   zero       result is zero               dbz       divide by zero (div/mod)

module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_hi,
    output logic             carry,
    output logic             ovf,
    output logic             zero,
    output logic             dbz
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int MSB = WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic             accept;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] dif;
    logic [2*WIDTH-1:0] prod;

    logic [WIDTH-1:0] res_y;
    logic [WIDTH-1:0] res_hi;
    logic             res_c;
    logic             res_v;
    logic             res_z;
    logic             res_dbz;
    logic             start_div;

    // Divider working registers
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] div_b;
    logic             div_mod;
    logic [CW-1:0]    count;

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] quo_nx;
    logic [WIDTH-1:0] div_res;

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign dif  = a - b;
    assign prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    // Single-cycle result path, evaluated on the operands being accepted
    always_comb begin
        res_y     = '0;
        res_hi    = '0;
        res_c     = 1'b0;
        res_v     = 1'b0;
        res_dbz   = 1'b0;
        start_div = 1'b0;
        case (op)
            4'h0: begin
                res_y = sum[WIDTH-1:0];
                res_c = sum[WIDTH];
                res_v = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
            end
            4'h1: begin
                res_y = dif;
                res_c = (a < b);
                res_v = (a[MSB] != b[MSB]) && (dif[MSB] != a[MSB]);
            end
            4'h2: {res_hi, res_y} = prod;
            4'h3: begin
                if (b == '0) begin
                    res_y   = '1;
                    res_dbz = 1'b1;
                end else begin
                    start_div = 1'b1;
                end
            end
            4'h4: begin
                if (b == '0) begin
                    res_y   = a;
                    res_dbz = 1'b1;
                end else begin
                    start_div = 1'b1;
                end
            end
            4'h5: res_y = a & b;
            4'h6: res_y = a | b;
            4'h7: res_y = a ^ b;
            4'h8: res_y = ~a;
            4'h9: res_y = ~b;
            4'hA: res_y = ~(a ^ b);
            4'hB: res_y = {{(WIDTH-1){1'b0}}, (a != '0) && (b != '0)};
            4'hC: res_y = {{(WIDTH-1){1'b0}}, (a != '0) || (b != '0)};
            4'hD: res_y = {{(WIDTH-1){1'b0}}, a == b};
            4'hE: res_y = {{(WIDTH-1){1'b0}}, a != b};
            default: ;
        endcase
        // The reserved opcode reports every flag as 0, including zero
        res_z = (op != 4'hF) && (res_y == '0) && (res_hi == '0);
    end

    // One restoring step: shift {rem,quo} left, trial-subtract divisor.
    // rem < div_b always holds, so a non-negative trial fits in WIDTH bits
    // and trial[WIDTH] is a clean borrow indicator.
    always_comb begin
        rem_sh  = {rem, quo[MSB]};
        trial   = rem_sh - {1'b0, div_b};
        rem_nx  = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_nx  = {quo[WIDTH-2:0], ~trial[WIDTH]};
        div_res = div_mod ? rem_nx : quo_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = start_div ? DIV : DONE;
                end
            end
            DIV: begin
                if (count == CW'(1)) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y       <= '0;
            y_hi    <= '0;
            carry   <= 1'b0;
            ovf     <= 1'b0;
            zero    <= 1'b0;
            dbz     <= 1'b0;
            rem     <= '0;
            quo     <= '0;
            div_b   <= '0;
            div_mod <= 1'b0;
            count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        div_b   <= b;
                        div_mod <= (op == 4'h4);
                        if (start_div) begin
                            rem   <= '0;
                            quo   <= a;
                            count <= CW'(WIDTH);
                        end else begin
                            y     <= res_y;
                            y_hi  <= res_hi;
                            carry <= res_c;
                            ovf   <= res_v;
                            zero  <= res_z;
                            dbz   <= res_dbz;
                        end
                    end
                end
                DIV: begin
                    rem   <= rem_nx;
                    quo   <= quo_nx;
                    count <= count - CW'(1);
                    // Last step: publish straight from the step outputs
                    if (count == CW'(1)) begin
                        y     <= div_res;
                        y_hi  <= '0;
                        carry <= 1'b0;
                        ovf   <= 1'b0;
                        zero  <= (div_res == '0);
                        dbz   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed self-checking bench for alu_seq (WIDTH=8)

module tb_alu_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] op;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] y;
    logic [7:0] y_hi;
    logic       carry;
    logic       ovf;
    logic       zero;
    logic       dbz;

    int n_checks = 0;
    int n_pass   = 0;

    alu_seq #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .y_hi      (y_hi),
        .carry     (carry),
        .ovf       (ovf),
        .zero      (zero),
        .dbz       (dbz)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one operation, wait (bounded) for the result, check it, then hand it off.
    task automatic run_vec(input string tag, input logic [7:0] va, input logic [7:0] vb,
                           input logic [3:0] vop, input logic [7:0] ey, input logic [7:0] ehi,
                           input logic ec, input logic ev, input logic ez, input logic ed,
                           input int elat);
        int  lat;
        logic rdy_low;
        @(negedge clk);
        check({tag, " in_ready_idle"}, in_ready, 1);
        a        = va;
        b        = vb;
        op       = vop;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat     = 1;
        rdy_low = 1'b1;
        @(negedge clk);
        while (!out_valid && lat < 40) begin
            if (in_ready) rdy_low = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (in_ready) rdy_low = 1'b0;
        check({tag, " out_valid"}, out_valid, 1);
        check({tag, " latency"}, lat, elat);
        check({tag, " in_ready_busy"}, rdy_low, 1);
        check({tag, " y"}, y, ey);
        check({tag, " y_hi"}, y_hi, ehi);
        check({tag, " carry"}, carry, ec);
        check({tag, " ovf"}, ovf, ev);
        check({tag, " zero"}, zero, ez);
        check({tag, " dbz"}, dbz, ed);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check({tag, " out_valid_drop"}, out_valid, 0);
        check({tag, " y_hold"}, y, ey);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        op        = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst in_ready", in_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        check("rst out_valid", out_valid, 0);
        check("rst y", y, 0);
        check("rst y_hi", y_hi, 0);
        check("rst flags", {carry, ovf, zero, dbz}, 0);
        check("rst in_ready_after", in_ready, 1);

        //      tag          a      b      op     y      y_hi   c     v     z     d     lat
        run_vec("add_ovf",   8'h7F, 8'h01, 4'h0, 8'h80, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1);
        run_vec("add_carry", 8'hFF, 8'h01, 4'h0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1);
        run_vec("sub_borrow",8'h00, 8'h01, 4'h1, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        run_vec("sub_ovf",   8'h80, 8'h01, 4'h1, 8'h7F, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1);
        run_vec("mul_ff",    8'hFF, 8'hFF, 4'h2, 8'h01, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        run_vec("mul_10",    8'h10, 8'h10, 4'h2, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        run_vec("div_200_7", 8'd200,8'd7,  4'h3, 8'h1C, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 9);
        run_vec("mod_200_7", 8'd200,8'd7,  4'h4, 8'h04, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 9);
        run_vec("div_5_9",   8'd5,  8'd9,  4'h3, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 9);
        run_vec("mod_5_9",   8'd5,  8'd9,  4'h4, 8'h05, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 9);
        run_vec("div_by0",   8'h2A, 8'h00, 4'h3, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1);
        run_vec("mod_by0",   8'h2A, 8'h00, 4'h4, 8'h2A, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1);
        run_vec("xor",       8'hA5, 8'h5A, 4'h7, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        run_vec("not_a",     8'h0F, 8'h33, 4'h8, 8'hF0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        run_vec("land_0",    8'h00, 8'h33, 4'hB, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1);
        run_vec("eq",        8'h03, 8'h03, 4'hD, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        run_vec("reserved",  8'h03, 8'h03, 4'hF, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1);

        // Backpressure: hold out_ready low in DONE while new operands are offered
        @(negedge clk);
        a = 8'h10; b = 8'h20; op = 4'h0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("bp out_valid", out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            a = 8'h01; b = 8'h01; op = 4'h0; in_valid = 1'b1;
            check("bp in_ready", in_ready, 0);
            check("bp hold", {out_valid, y, y_hi, carry, ovf, zero, dbz}, {1'b1, 8'h30, 8'h00, 4'b0000});
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp no_extra", out_valid, 0);
        end
        check("bp y_kept", y, 8'h30);

        // Reset in the 4th cycle of a divide aborts it
        @(negedge clk);
        a = 8'd200; b = 8'd7; op = 4'h3; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("abort busy", in_ready, 0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort out_valid", out_valid, 0);
        check("abort outputs", {y, y_hi, carry, ovf, zero, dbz}, 0);
        check("abort in_ready", in_ready, 1);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("abort no_result", out_valid, 0);
        end

        run_vec("add_after", 8'd3, 8'd4, 4'h0, 8'h07, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
